// File: rtl/m_fetch_queue_if.sv
// Fetch queue bus: redirect/hold control, imem port and ID-side handshake.
// master = the queue, slave = the surrounding pipeline and memory.
interface m_fetch_queue_if #(
   parameter int AW = 11,
   parameter int DW = 32,
   parameter int CW = 3
);
   logic          w_redir;
   logic [AW-1:0] w_redir_pc;
   logic          w_hold;
   logic [AW-1:0] w_imem_addr;
   logic [DW-1:0] w_imem_dout;
   logic          w_id_valid;
   logic          w_id_ready;
   logic [DW-1:0] w_id_ir;
   logic [AW-1:0] w_id_pc;
   logic [AW-1:0] w_id_pc4;
   logic [CW-1:0] w_count;

   modport master (
      input  w_redir, w_redir_pc, w_hold,
      input  w_imem_dout, w_id_ready,
      output w_imem_addr, w_id_valid,
      output w_id_ir, w_id_pc, w_id_pc4, w_count
   );

   modport slave (
      output w_redir, w_redir_pc, w_hold,
      output w_imem_dout, w_id_ready,
      input  w_imem_addr, w_id_valid,
      input  w_id_ir, w_id_pc, w_id_pc4, w_count
   );
endinterface

// File: rtl/m_fetch_queue.sv
// Instruction prefetch queue: owns fetch PC, buffers imem words for ID.
// Redirect flushes queued and in-flight words and restarts fetch.
module m_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 11,
   parameter int DW    = 32
) (
   input logic           w_clk,
   input logic           w_rst,
   m_fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

   logic [AW-1:0] r_fpc;
   logic [AW-1:0] r_ipc;
   logic          r_infl;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [DW-1:0] r_ir [DEPTH];
   logic [AW-1:0] r_pc [DEPTH];

   logic          w_valid;
   logic          w_deq;
   logic          w_enq;
   logic          w_issue;
   logic [AW-1:0] w_addr;
   logic [CW:0]   w_occ;

   // occupancy counts the in-flight word so the queue can never overflow
   always_comb begin
      w_valid = (r_count != '0);
      w_deq   = w_valid & bus.w_id_ready & ~bus.w_redir;
      w_enq   = r_infl & ~bus.w_redir;
      w_addr  = bus.w_redir ? bus.w_redir_pc : r_fpc;
      w_occ   = {1'b0, r_count} - (CW + 1)'(w_deq)
              + (CW + 1)'(r_infl);
      w_issue = ~bus.w_hold & (bus.w_redir | (w_occ < FULL));
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_fpc   <= '0;
         r_ipc   <= '0;
         r_infl  <= 1'b0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_infl <= w_issue;
         if (w_issue) begin
            r_ipc <= w_addr;
            r_fpc <= w_addr + AW'(1);
         end else if (bus.w_redir) begin
            r_fpc <= bus.w_redir_pc;
         end
         if (bus.w_redir) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_enq) r_tail <= r_tail + PW'(1);
            if (w_deq) r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
         end
      end
   end

   always_ff @(posedge w_clk) begin
      if (!w_rst && w_enq) begin
         r_ir[r_tail] <= bus.w_imem_dout;
         r_pc[r_tail] <= r_ipc;
      end
   end

   always_comb begin
      bus.w_imem_addr = w_addr;
      bus.w_id_valid  = w_valid;
      bus.w_count     = r_count;
      bus.w_id_ir     = '0;
      bus.w_id_pc     = '0;
      bus.w_id_pc4    = '0;
      if (w_valid) begin
         bus.w_id_ir  = r_ir[r_head];
         bus.w_id_pc  = r_pc[r_head];
         bus.w_id_pc4 = r_pc[r_head] + AW'(1);
      end
   end
endmodule

// File: tb/tb_m_fetch_queue.sv
// Bench for m_fetch_queue: queue-based reference model plus scenario tasks.
// The bench also plays the 1-cycle registered instruction memory.
module tb_m_fetch_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 11;
   localparam int DW    = 32;
   localparam int CW    = 3;

   logic          clk;
   logic          rst;
   logic          redir;
   logic [AW-1:0] rpc;
   logic          hold;
   logic          ready;
   logic [DW-1:0] dout;

   logic [DW-1:0] imem [1 << AW];

   int nv;
   int nerr;

   // reference model: expected queue contents as a list of PCs
   int mq[$];
   bit m_infl;
   int m_ipc;
   int m_fpc;
   bit m_init;

   logic          s_valid;
   logic [AW-1:0] s_pc;
   logic [AW-1:0] s_pc4;
   logic [DW-1:0] s_ir;
   logic [CW-1:0] s_count;
   logic [AW-1:0] s_addr;
   int dlv[$];
   int dlv4[$];

   m_fetch_queue_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

   assign bus.w_redir     = redir;
   assign bus.w_redir_pc  = rpc;
   assign bus.w_hold      = hold;
   assign bus.w_id_ready  = ready;
   assign bus.w_imem_dout = dout;

   m_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .w_clk (clk),
      .w_rst (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      logic [AW-1:0] a;
      logic [AW-1:0] ea;
      bit ev;
      @(negedge clk);
      a       = bus.w_imem_addr;
      s_valid = bus.w_id_valid;
      s_pc    = bus.w_id_pc;
      s_pc4   = bus.w_id_pc4;
      s_ir    = bus.w_id_ir;
      s_count = bus.w_count;
      s_addr  = a;
      if (m_init) begin
         ev = (mq.size() != 0);
         ea = redir ? rpc : m_fpc[AW-1:0];
         nv++;
         if (s_valid !== ev) begin
            nerr++;
            $display("FAIL model_valid got %b exp %b t=%0t", s_valid, ev, $time);
         end
         nv++;
         if (s_count !== CW'(mq.size())) begin
            nerr++;
            $display("FAIL model_count got %0d exp %0d t=%0t", s_count, mq.size(), $time);
         end
         nv++;
         if (a !== ea) begin
            nerr++;
            $display("FAIL model_addr got %h exp %h t=%0t", a, ea, $time);
         end
         if (ev) begin
            nv++;
            if (s_pc !== AW'(mq[0]) || s_pc4 !== AW'((mq[0] + 1) % (1 << AW))
                || s_ir !== imem[mq[0]]) begin
               nerr++;
               $display("FAIL model_head got pc %h pc4 %h ir %h exp pc %h ir %h",
                        s_pc, s_pc4, s_ir, mq[0], imem[mq[0]]);
            end
         end else begin
            nv++;
            if ({s_ir, s_pc, s_pc4} !== '0) begin
               nerr++;
               $display("FAIL model_empty_zero got ir %h pc %h pc4 %h", s_ir, s_pc, s_pc4);
            end
         end
      end
      if (!rst && s_valid === 1'b1 && ready && !redir) begin
         dlv.push_back(int'(s_pc));
         dlv4.push_back(int'(s_pc4));
      end
      if (rst) begin
         mq.delete();
         m_infl = 0;
         m_fpc  = 0;
         m_init = 1;
      end else if (m_init) begin
         if (redir) begin
            mq.delete();
         end else begin
            if (mq.size() != 0 && ready) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_ipc);
         end
         if (!hold && mq.size() < DEPTH) begin
            m_infl = 1;
            m_ipc  = redir ? int'(rpc) : m_fpc;
            m_fpc  = (m_ipc + 1) % (1 << AW);
         end else begin
            m_infl = 0;
            if (redir) m_fpc = int'(rpc);
         end
      end
      @(posedge clk);
      #1;
      dout = imem[a];
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      redir = 1'b0;
      hold  = 1'b0;
      ready = 1'b0;
      rpc   = '0;
      step();
      step();
      rst = 1'b0;
      dlv.delete();
      dlv4.delete();
   endtask

   task automatic test_reset();
      do_reset();
      step();
      nv++;
      if (s_valid !== 1'b0 || s_count !== '0) begin
         nerr++;
         $display("FAIL reset_state got valid %b count %0d exp 0 0", s_valid, s_count);
      end
      nv++;
      if ({s_ir, s_pc, s_pc4} !== '0 || s_addr !== '0) begin
         nerr++;
         $display("FAIL reset_outputs got ir %h pc %h pc4 %h addr %h exp 0",
                  s_ir, s_pc, s_pc4, s_addr);
      end
   endtask

   task automatic test_startup();
      do_reset();
      ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (c < 2) begin
            nv++;
            if (s_valid !== 1'b0) begin
               nerr++;
               $display("FAIL startup_early_valid c=%0d got %b exp 0", c, s_valid);
            end
         end else begin
            nv++;
            if (s_valid !== 1'b1 || s_pc !== AW'(c - 2)
                || s_pc4 !== AW'(c - 1) || s_ir !== imem[c - 2]) begin
               nerr++;
               $display("FAIL startup_seq c=%0d got v %b pc %h pc4 %h exp pc %h",
                        c, s_valid, s_pc, s_pc4, c - 2);
            end
         end
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      for (int c = 0; c < 8; c++) step();
      nv++;
      if (s_count !== CW'(4) || s_addr !== AW'(4)) begin
         nerr++;
         $display("FAIL full_saturate got count %0d addr %h exp 4 004", s_count, s_addr);
      end
      ready = 1'b1;
      dlv.delete();
      for (int c = 0; c < 8; c++) begin
         step();
         nv++;
         if (s_valid !== 1'b1) begin
            nerr++;
            $display("FAIL full_drain_gap c=%0d got %b exp 1", c, s_valid);
         end
      end
      for (int i = 0; i < 8; i++) begin
         nv++;
         if (dlv.size() <= i || dlv[i] != i) begin
            nerr++;
            $display("FAIL full_drain_order i=%0d got %0d exp %0d",
                     i, (dlv.size() > i) ? dlv[i] : -1, i);
         end
      end
   endtask

   task automatic test_redirect_flush();
      bit bad;
      do_reset();
      redir = 1'b1;
      rpc   = AW'(5);
      step();
      redir = 1'b0;
      for (int c = 0; c < 7; c++) step();
      nv++;
      if (s_count !== CW'(4) || s_pc !== AW'(5)) begin
         nerr++;
         $display("FAIL flush_setup got count %0d pc %h exp 4 005", s_count, s_pc);
      end
      dlv.delete();
      redir = 1'b1;
      rpc   = AW'('h40);
      ready = 1'b1;
      step();
      redir = 1'b0;
      step();
      nv++;
      if (s_count !== '0 || s_valid !== 1'b0) begin
         nerr++;
         $display("FAIL flush_empty got count %0d valid %b exp 0 0", s_count, s_valid);
      end
      step();
      nv++;
      if (s_valid !== 1'b1 || s_pc !== AW'('h40)) begin
         nerr++;
         $display("FAIL flush_restart got valid %b pc %h exp 1 040", s_valid, s_pc);
      end
      for (int c = 0; c < 5; c++) step();
      bad = 0;
      foreach (dlv[i]) if (dlv[i] >= 5 && dlv[i] <= 8) bad = 1;
      nv++;
      if (bad || dlv.size() == 0 || dlv[0] != 'h40) begin
         nerr++;
         $display("FAIL flush_stale got first %0d size %0d stale %b exp 64 no stale",
                  (dlv.size() > 0) ? dlv[0] : -1, dlv.size(), bad);
      end
   endtask

   task automatic test_wrap();
      int exp_pc[4];
      exp_pc = '{'h7FE, 'h7FF, 'h000, 'h001};
      do_reset();
      ready = 1'b1;
      for (int c = 0; c < 4; c++) step();
      dlv.delete();
      dlv4.delete();
      redir = 1'b1;
      rpc   = AW'('h7FE);
      step();
      redir = 1'b0;
      for (int c = 0; c < 6; c++) step();
      for (int i = 0; i < 4; i++) begin
         nv++;
         if (dlv.size() <= i || dlv[i] != exp_pc[i]) begin
            nerr++;
            $display("FAIL wrap_pc i=%0d got %h exp %h",
                     i, (dlv.size() > i) ? dlv[i] : -1, exp_pc[i]);
         end
      end
      nv++;
      if (dlv4.size() < 2 || dlv4[1] != 0) begin
         nerr++;
         $display("FAIL wrap_pc4 got %h exp 000", (dlv4.size() > 1) ? dlv4[1] : -1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ready = 1'b1;
      for (int c = 0; c < 6; c++) step();
      rst   = 1'b1;
      redir = 1'b1;
      rpc   = AW'('h10);
      step();
      rst   = 1'b0;
      redir = 1'b0;
      dlv.delete();
      step();
      nv++;
      if (s_count !== '0 || s_valid !== 1'b0 || s_addr !== '0) begin
         nerr++;
         $display("FAIL rstmid_state got count %0d valid %b addr %h exp 0 0 000",
                  s_count, s_valid, s_addr);
      end
      for (int c = 0; c < 4; c++) step();
      nv++;
      if (dlv.size() == 0 || dlv[0] != 0) begin
         nerr++;
         $display("FAIL rstmid_restart got %h exp 000", (dlv.size() > 0) ? dlv[0] : -1);
      end
   endtask

   task automatic test_hold_drain();
      do_reset();
      step();
      step();
      hold = 1'b1;
      step();
      step();
      nv++;
      if (s_count !== CW'(2)) begin
         nerr++;
         $display("FAIL hold_setup got count %0d exp 2", s_count);
      end
      ready = 1'b1;
      dlv.delete();
      for (int c = 0; c < 4; c++) step();
      nv++;
      if (s_count !== '0 || s_valid !== 1'b0 || s_addr !== AW'(2)) begin
         nerr++;
         $display("FAIL hold_drain got count %0d valid %b addr %h exp 0 0 002",
                  s_count, s_valid, s_addr);
      end
      hold = 1'b0;
      for (int c = 0; c < 5; c++) step();
      for (int i = 0; i < 4; i++) begin
         nv++;
         if (dlv.size() <= i || dlv[i] != i) begin
            nerr++;
            $display("FAIL hold_resume i=%0d got %0d exp %0d",
                     i, (dlv.size() > i) ? dlv[i] : -1, i);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit bad;
      do_reset();
      ready = 1'b1;
      for (int c = 0; c < 4; c++) step();
      dlv.delete();
      redir = 1'b1;
      rpc   = AW'('h100);
      step();
      rpc = AW'('h200);
      step();
      redir = 1'b0;
      for (int c = 0; c < 5; c++) step();
      bad = 0;
      foreach (dlv[i]) if (dlv[i] >= 'h100 && dlv[i] < 'h200) bad = 1;
      nv++;
      if (bad || dlv.size() < 2 || dlv[0] != 'h200 || dlv[1] != 'h201) begin
         nerr++;
         $display("FAIL b2b_redirect got first %h size %0d stale %b exp 200 201",
                  (dlv.size() > 0) ? dlv[0] : -1, dlv.size(), bad);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 800; c++) begin
         ready = ($urandom % 4) != 0;
         hold  = ($urandom % 5) == 0;
         redir = ($urandom % 25) == 0;
         rpc   = AW'($urandom);
         rst   = ($urandom % 200) == 0;
         step();
      end
      rst   = 1'b0;
      redir = 1'b0;
      hold  = 1'b0;
   endtask

   initial begin
      nv     = 0;
      nerr   = 0;
      m_init = 0;
      m_infl = 0;
      m_ipc  = 0;
      m_fpc  = 0;
      dout   = '0;
      rst    = 1'b1;
      redir  = 1'b0;
      hold   = 1'b0;
      ready  = 1'b0;
      rpc    = '0;
      for (int i = 0; i < (1 << AW); i++) imem[i] = $urandom;
      test_reset();
      test_startup();
      test_full_stall();
      test_redirect_flush();
      test_wrap();
      test_reset_mid();
      test_hold_drain();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
      $finish;
   end
endmodule
